// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word data memory with LSU front end, configurable read latency and fault detection
module dmem_lsu #(
    parameter int ADDR_W       = 32,
    parameter int DEPTH_WORDS  = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       dbg_word0,
    output logic [31:0]       dbg_word1
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [2:0]        cnt;
    logic              write_q, unsigned_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cur_write, cur_unsigned;
    logic [1:0]        cur_size, lane;
    logic [ADDR_W-1:0] cur_addr;
    logic [IW-1:0]     widx;
    logic [31:0]       rword, shifted, ld_data, wrep;
    logic [3:0]        be;
    logic              accept, bad, err_now;

    initial for (int k = 0; k < DEPTH_WORDS; k++) mem[k] = 32'(2 * k);

    // In IDLE the live request is used; afterwards the fields captured at acceptance.
    assign cur_write    = (state == IDLE) ? req_write    : write_q;
    assign cur_unsigned = (state == IDLE) ? req_unsigned : unsigned_q;
    assign cur_size     = (state == IDLE) ? req_size     : size_q;
    assign cur_addr     = (state == IDLE) ? req_addr     : addr_q;
    assign lane         = cur_addr[1:0];
    assign widx         = cur_addr[IW+1:2];
    assign rword        = mem[widx];
    assign shifted      = rword >> {lane, 3'b000};

    assign accept  = (state == IDLE) && req_valid && !reset;
    assign bad     = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (|req_addr[ADDR_W-1:IW+2]);
    assign err_now = accept && bad;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign dbg_word0 = mem[0];
    assign dbg_word1 = mem[1];

    always_comb begin
        ld_data  = (cur_size == 2'b00) ? {{24{~cur_unsigned & shifted[7]}}, shifted[7:0]} :
                   (cur_size == 2'b01) ? {{16{~cur_unsigned & shifted[15]}}, shifted[15:0]} : rword;
        be       = (cur_size == 2'b00) ? (4'b0001 << lane) :
                   (cur_size == 2'b01) ? (4'b0011 << lane) : 4'b1111;
        wrep     = (cur_size == 2'b00) ? {4{req_wdata[7:0]}} :
                   (cur_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
        state_nx = (state == IDLE) ? (accept ? ((req_write || bad || READ_LATENCY == 1) ? RESP : WAIT) : IDLE) :
                   (state == WAIT) ? ((cnt == 3'd0) ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_rdata <= (state_nx == RESP && !cur_write && !err_now) ? ld_data : '0;
            rsp_err   <= err_now;
            if (accept) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                size_q     <= req_size;
                addr_q     <= req_addr;
                cnt        <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_write && !bad)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized + directed check of dmem_lsu (latency 1 and 3 instances) against an array model
module tb_dmem_lsu;
    logic        clk = 0, reset = 1;
    logic        rv[2], rr[2], rw[2], ru[2], rsv[2], rse[2];
    logic [31:0] ra[2], wd[2], rd[2], d0[2], d1[2];
    logic [1:0]  rs[2];
    logic [31:0] mdl[2][64];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(32), .DEPTH_WORDS(64), .READ_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_size(rs[0]), .req_unsigned(ru[0]), .req_wdata(wd[0]),
        .rsp_valid(rsv[0]), .rsp_rdata(rd[0]), .rsp_err(rse[0]), .dbg_word0(d0[0]), .dbg_word1(d1[0]));

    dmem_lsu #(.ADDR_W(32), .DEPTH_WORDS(64), .READ_LATENCY(3)) u1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_size(rs[1]), .req_unsigned(ru[1]), .req_wdata(wd[1]),
        .rsp_valid(rsv[1]), .rsp_rdata(rd[1]), .rsp_err(rse[1]), .dbg_word0(d0[1]), .dbg_word1(d1[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One request on instance d; model updates at acceptance, response timing checked cycle by cycle.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [1:0] s,
                       input bit u, input logic [31:0] v);
        int rl, lat, off, wi, bits;
        bit e;
        longint unsigned mask, x;
        logic [31:0] er;
        rl   = d ? 3 : 1;
        e    = s == 3 || (s == 1 && a[0]) || (s == 2 && a[1:0] != 0) || a >= 32'd256;
        off  = int'(a % 4);
        wi   = int'((a / 4) % 64);
        bits = (s == 3) ? 32 : (8 << s);
        mask = (64'd1 << bits) - 1;
        er   = 0;
        if (!e && w) begin
            mdl[d][wi] = 32'((longint'(mdl[d][wi]) & ~(mask << (8 * off))) | ((longint'(v) & mask) << (8 * off)));
        end else if (!e) begin
            x = (longint'(mdl[d][wi]) >> (8 * off)) & mask;
            if (!u && s < 2 && x >= (mask + 1) / 2) x = x | ~mask;
            er = x[31:0];
        end
        lat = (w || e) ? 1 : rl;
        @(negedge clk);
        rv[d] = 1; rw[d] = w; ra[d] = a; rs[d] = s; ru[d] = u; wd[d] = v;
        check("ready_before", {31'd0, rr[d]}, 1);
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rv[d] = 0; ra[d] = $urandom; wd[d] = $urandom; rs[d] = 2'($urandom); ru[d] = ~u; rw[d] = ~w;
            end
            check("rsp_valid", {31'd0, rsv[d]}, {31'd0, k == lat});
            check("rsp_rdata", rd[d], (k == lat) ? er : 32'd0);
            check("rsp_err", {31'd0, rse[d]}, {31'd0, k == lat && e});
            check("req_ready", {31'd0, rr[d]}, {31'd0, k == lat + 1});
        end
        check("dbg_word0", d0[d], mdl[d][0]);
        check("dbg_word1", d1[d], mdl[d][1]);
    endtask

    initial begin
        bit w;
        logic [31:0] a;
        logic [1:0] s;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; rw[d] = 0; ra[d] = 0; rs[d] = 0; ru[d] = 0; wd[d] = 0;
            for (int k = 0; k < 64; k++) mdl[d][k] = 32'(2 * k);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", {31'd0, rsv[d]}, 0);
            check("rst_rdata", rd[d], 0);
            check("rst_err", {31'd0, rse[d]}, 0);
            check("rst_ready", {31'd0, rr[d]}, 1);
        end
        reset = 0;

        txn(0, 0, 32'h10, 2, 0, 0);
        check("dbg1_init", d1[0], 32'h2);
        txn(0, 1, 32'h20, 2, 0, 32'h800080F0);
        txn(0, 0, 32'h20, 0, 0, 0);
        txn(0, 0, 32'h20, 0, 1, 0);
        txn(0, 0, 32'h22, 1, 0, 0);
        txn(0, 0, 32'h22, 1, 1, 0);
        txn(0, 1, 32'h25, 0, 0, 32'h000000AB);
        txn(0, 0, 32'h24, 2, 0, 0);
        check("mem9_const", mdl[0][9], 32'h0000AB12);
        txn(0, 1, 32'h00, 1, 0, 32'h00001234);
        check("dbg0_const", d0[0], 32'h00001234);
        txn(0, 0, 32'h06, 2, 0, 0);
        txn(0, 0, 32'h03, 1, 0, 0);
        txn(0, 0, 32'h08, 3, 0, 0);
        txn(0, 1, 32'h100, 2, 0, 32'hFFFFFFFF);
        txn(0, 0, 32'h00, 2, 0, 0);
        txn(1, 0, 32'h10, 2, 0, 0);
        txn(1, 1, 32'h30, 1, 0, 32'h0000BEEF);
        txn(1, 0, 32'h30, 1, 0, 0);

        // Back-to-back loads held valid on the latency-3 instance: one acceptance every 4 cycles.
        @(negedge clk);
        rv[1] = 1; rw[1] = 0; ra[1] = 32'h10; rs[1] = 2; ru[1] = 0;
        for (int j = 0; j < 12; j++) begin
            check("b2b_ready", {31'd0, rr[1]}, {31'd0, j % 4 == 0});
            check("b2b_valid", {31'd0, rsv[1]}, {31'd0, j % 4 == 3});
            check("b2b_rdata", rd[1], (j % 4 == 3) ? mdl[1][4] : 32'd0);
            @(negedge clk);
        end
        rv[1] = 0;

        // Reset while the latency-3 load sits in WAIT: no response must follow.
        @(negedge clk);
        rv[1] = 1; ra[1] = 32'h14; rs[1] = 2; rw[1] = 0;
        @(negedge clk);
        rv[1] = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        for (int j = 0; j < 4; j++) begin
            check("rst_wait_valid", {31'd0, rsv[1]}, 0);
            check("rst_wait_ready", {31'd0, rr[1]}, 1);
            @(negedge clk);
        end

        // Store presented on a reset edge must not be accepted.
        reset = 1; rv[0] = 1; rw[0] = 1; ra[0] = 0; rs[0] = 2; wd[0] = 32'hDEADBEEF;
        @(negedge clk);
        reset = 0; rv[0] = 0;
        check("rst_store_dbg0", d0[0], mdl[0][0]);
        check("rst_store_valid", {31'd0, rsv[0]}, 0);
        txn(0, 0, 32'h00, 2, 0, 0);

        repeat (400) begin
            w = 1'($urandom);
            s = ($urandom % 8 < 7) ? 2'($urandom % 3) : 2'b11;
            a = ($urandom % 10 == 0) ? 32'($urandom) : 32'($urandom % 32'h110);
            if ($urandom % 4 != 0) a = (s == 2) ? (a & ~32'd3) : (s == 1) ? (a & ~32'd1) : a;
            txn(int'($urandom % 2), w, a, s, 1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
